fpu: RTL and testbench
======================

Name: fpu

Overview:
- Single-precision (IEEE-754 binary32) floating-point unit.
- Performs add, subtract and multiply on two 32-bit operands.
- Multi-cycle FSM with a ready/ack handshake on both input and output.
- Sits beside the integer datapath as the processor's FP execution unit.

Parameters:
- none; operand and result width are fixed at 32 bits.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- operation  in  4  opcode: 4'b0000 add, 4'b0001 subtract (a-b), 4'b0010 multiply; all other codes unsupported.
- data_a  in  32  operand A, binary32.
- data_b  in  32  operand B, binary32.
- input_rdy  in  1  requester has valid operands and opcode.
- input_ack  out  1  operands accepted; held high until the output handshake completes.
- output_rdy  out  1  result valid.
- output_ack  in  1  consumer has taken the result.
- result  out  32  binary32 result.

Behaviour:
- Reset (clock is single; reset synchronous, active-high): state=IDLE, result=0, input_ack=0, output_rdy=0. Reset mid-operation aborts the operation and discards it.
- FSM sequence: IDLE -> UNPACK -> ALIGN -> COMPUTE -> NORMALIZE -> PACK -> DONE -> IDLE.
- IDLE: when input_rdy=1, latch data_a, data_b and operation; set input_ack=1; go to UNPACK. Inputs are ignored at all other times.
- Each subsequent state lasts exactly one cycle. output_rdy rises on the 6th rising edge after the accepting edge.
- DONE: output_rdy=1 and result held stable. When output_ack=1, clear output_rdy and input_ack and return to IDLE.
- If input_rdy is still high in IDLE, a new operation is accepted on the next edge.
- UNPACK: split sign, 8-bit exponent and 23-bit fraction; add the implicit 1 for normal numbers.
- Denormal inputs are flushed to signed zero.
- Add/sub:
  - Subtract inverts the sign of B.
  - Shift the smaller-exponent mantissa right by the exponent difference; differences of 25 or more make it zero.
  - Add or subtract magnitudes according to the signs. Result sign is that of the larger magnitude.
  - An exact zero result is +0.
- Multiply:
  - sign = sa XOR sb; exponent = ea + eb - 127.
  - 24x24 mantissa product, then normalize by 0 or 1 bit.
- NORMALIZE: a single-cycle leading-one detect and shift. Carry-out shifts right 1 and increments the exponent.
- Rounding: truncation (round toward zero) for all operations.
- Exponent overflow (>=255) gives signed infinity. Underflow (<=0) gives signed zero.
- Special cases are resolved in UNPACK and bypass the arithmetic; latency is unchanged:
  - Any NaN operand, or an unsupported opcode, gives canonical NaN 32'hFFFFFFFF.
  - inf + finite gives that inf. inf + inf of the same sign gives that inf. inf - inf gives 32'hFFFFFFFF.
  - inf * nonzero gives signed inf. inf * 0 gives 32'hFFFFFFFF.
  - x + 0 gives x. x * 0 gives signed zero.

Optional Feature:
- Macro FPU_MUL_EN.
- Defined: opcode 4'b0010 performs multiply as above, including the 24x24 multiplier.
- Undefined: no multiplier is synthesized; opcode 4'b0010 is treated as unsupported and returns 32'hFFFFFFFF with identical latency and handshake.

Test Plan:
- add, 32'h3F800000 (1.0) + 32'h3C23D70A -> 32'h3F8147AE (truncated); output_rdy 6 cycles after accept; input_ack=1 while output_rdy=1.
- add, 32'h41A80000 (21.0) + 32'h3E947AE1 -> 32'h41AA51EB; then -1.0 + 12.2 (32'hBF800000 + 32'h4143 3333) -> 32'h41333333; and -1.0 + -12.2 -> 32'hC1533333.
- add, 32'h7E967699 + 32'hBF8CCCCD -> 32'h7E967699 (small operand fully shifted out).
- specials: 32'h7F800000 + 32'hBF8CCCCD -> 32'h7F800000; 32'hFF8CCCCD + 32'h7F8CCCCD -> 32'hFFFFFFFF; opcode 4'b0111 -> 32'hFFFFFFFF.
- multiply (FPU_MUL_EN defined), 32'h40000000 * 32'h40000000 -> 32'h40800000.
- handshake and reset:
  - Hold output_ack=0 for 10 cycles: result and output_rdy stay stable.
  - Assert output_ack: both flags drop the next edge.
  - Assert reset during COMPUTE: all outputs are 0 the next edge.

Source files
------------

// File: rtl/fpu.sv
// Multi-cycle IEEE-754 binary32 add/subtract/multiply unit with ready/ack handshakes.
// Define FPU_MUL_EN to build the 24x24 multiplier; otherwise multiply returns canonical NaN.
module fpu (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  operation,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        input_rdy,
  output logic        input_ack,
  output logic        output_rdy,
  input  logic        output_ack,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_COMPUTE, S_NORMALIZE, S_PACK, S_DONE
  } state_t;

  localparam logic [31:0] QNAN   = 32'hFFFF_FFFF;
  localparam logic [3:0]  OP_ADD = 4'b0000;
  localparam logic [3:0]  OP_SUB = 4'b0001;
`ifdef FPU_MUL_EN
  localparam logic [3:0]  OP_MUL = 4'b0010;
`endif

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d, result_q, result_d, special_res_q, special_res_d;
  logic [3:0]         op_q, op_d;
  logic               in_ack_q, in_ack_d, out_rdy_q, out_rdy_d;
  logic               is_mul_q, is_mul_d, special_q, special_d;
  logic               sa_q, sa_d, sb_q, sb_d, sx_q, sx_d, sy_q, sy_d;
  logic               sign_q, sign_d, zero_q, zero_d;
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [23:0]        ma_q, ma_d, mb_q, mb_d, mx_q, mx_d, my_q, my_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [47:0]        mant_q, mant_d;

  // Combinational helpers
  logic        add_op, mul_op, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, found;
  logic [7:0]  diff;
  logic [24:0] sum;
  logic [23:0] nm;
  logic [4:0]  lz;

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    in_ack_d      = in_ack_q;
    out_rdy_d     = out_rdy_q;
    result_d      = result_q;
    is_mul_d      = is_mul_q;
    special_d     = special_q;
    special_res_d = special_res_q;
    sa_d          = sa_q;
    sb_d          = sb_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    sign_d        = sign_q;
    zero_d        = zero_q;
    ea_d          = ea_q;
    eb_d          = eb_q;
    ma_d          = ma_q;
    mb_d          = mb_q;
    mx_d          = mx_q;
    my_d          = my_q;
    exp_d         = exp_q;
    mant_d        = mant_q;
    add_op        = (op_q == OP_ADD) || (op_q == OP_SUB);
`ifdef FPU_MUL_EN
    mul_op        = (op_q == OP_MUL);
`else
    mul_op        = 1'b0;
`endif
    a_zero        = (a_q[30:23] == 8'd0);
    b_zero        = (b_q[30:23] == 8'd0);
    a_inf         = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf         = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    a_nan         = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan         = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    diff          = 8'd0;
    sum           = 25'd0;
    nm            = 24'd0;
    lz            = 5'd0;
    found         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (input_rdy) begin
          a_d      = data_a;
          b_d      = data_b;
          op_d     = operation;
          in_ack_d = 1'b1;
          state_d  = S_UNPACK;
        end
      end

      S_UNPACK: begin
        // Denormals are flushed: exponent field 0 means a signed zero operand.
        sa_d      = a_q[31];
        sb_d      = b_q[31] ^ (op_q == OP_SUB);
        ea_d      = a_zero ? 8'd0 : a_q[30:23];
        eb_d      = b_zero ? 8'd0 : b_q[30:23];
        ma_d      = a_zero ? 24'd0 : {1'b1, a_q[22:0]};
        mb_d      = b_zero ? 24'd0 : {1'b1, b_q[22:0]};
        is_mul_d  = mul_op;
        special_d = 1'b1;
        if ((!add_op && !mul_op) || a_nan || b_nan) begin
          special_res_d = QNAN;
        end else if (add_op) begin
          if (a_inf && b_inf)
            special_res_d = (sa_d == sb_d) ? {sa_d, 8'hFF, 23'd0} : QNAN;
          else if (a_inf)
            special_res_d = {sa_d, 8'hFF, 23'd0};
          else if (b_inf)
            special_res_d = {sb_d, 8'hFF, 23'd0};
          else if (b_zero)
            special_res_d = {sa_d, ea_d, ma_d[22:0]};
          else if (a_zero)
            special_res_d = {sb_d, eb_d, mb_d[22:0]};
          else
            special_d = 1'b0;
        end else begin
          if (a_inf || b_inf)
            special_res_d = (a_zero || b_zero) ? QNAN : {sa_d ^ sb_d, 8'hFF, 23'd0};
          else if (a_zero || b_zero)
            special_res_d = {sa_d ^ sb_d, 31'd0};
          else
            special_d = 1'b0;
        end
        state_d = S_ALIGN;
      end

      S_ALIGN: begin
        if (is_mul_q) begin
          exp_d = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
        end else if (ea_q >= eb_q) begin
          diff  = ea_q - eb_q;
          exp_d = $signed({2'b00, ea_q});
          mx_d  = ma_q;
          sx_d  = sa_q;
          my_d  = (diff >= 8'd25) ? 24'd0 : (mb_q >> diff);
          sy_d  = sb_q;
        end else begin
          diff  = eb_q - ea_q;
          exp_d = $signed({2'b00, eb_q});
          mx_d  = mb_q;
          sx_d  = sb_q;
          my_d  = (diff >= 8'd25) ? 24'd0 : (ma_q >> diff);
          sy_d  = sa_q;
        end
        state_d = S_COMPUTE;
      end

      S_COMPUTE: begin
        zero_d = 1'b0;
        if (is_mul_q) begin
          sign_d = sa_q ^ sb_q;
`ifdef FPU_MUL_EN
          mant_d = {24'd0, ma_q} * {24'd0, mb_q};
`else
          mant_d = 48'd0;
`endif
        end else begin
          if (sx_q == sy_q) begin
            sum    = {1'b0, mx_q} + {1'b0, my_q};
            sign_d = sx_q;
          end else if (mx_q >= my_q) begin
            sum    = {1'b0, mx_q - my_q};
            sign_d = sx_q;
          end else begin
            sum    = {1'b0, my_q - mx_q};
            sign_d = sy_q;
          end
          mant_d = {23'd0, sum};
          if (sum == 25'd0) begin
            zero_d = 1'b1;
            sign_d = 1'b0;
          end
        end
        state_d = S_NORMALIZE;
      end

      S_NORMALIZE: begin
        if (is_mul_q) begin
          if (mant_q[47]) begin
            nm    = mant_q[47:24];
            exp_d = exp_q + 10'sd1;
          end else begin
            nm    = mant_q[46:23];
          end
        end else if (mant_q[24]) begin
          nm    = mant_q[24:1];
          exp_d = exp_q + 10'sd1;
        end else begin
          for (int i = 23; i >= 0; i--) begin
            if (!found && mant_q[i]) begin
              lz    = 5'(23 - i);
              found = 1'b1;
            end
          end
          nm    = mant_q[23:0] << lz;
          exp_d = exp_q - $signed({5'd0, lz});
        end
        mant_d  = {24'd0, nm};
        state_d = S_PACK;
      end

      S_PACK: begin
        if (special_q)
          result_d = special_res_q;
        else if (zero_q)
          result_d = 32'd0;
        else if (exp_q >= 10'sd255)
          result_d = {sign_q, 8'hFF, 23'd0};
        else if (exp_q <= 10'sd0)
          result_d = {sign_q, 31'd0};
        else
          result_d = {sign_q, exp_q[7:0], mant_q[22:0]};
        state_d = S_DONE;
      end

      S_DONE: begin
        if (!out_rdy_q) begin
          out_rdy_d = 1'b1;
        end else if (output_ack) begin
          out_rdy_d = 1'b0;
          in_ack_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      op_q          <= 4'd0;
      in_ack_q      <= 1'b0;
      out_rdy_q     <= 1'b0;
      result_q      <= 32'd0;
      is_mul_q      <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= 32'd0;
      sa_q          <= 1'b0;
      sb_q          <= 1'b0;
      sx_q          <= 1'b0;
      sy_q          <= 1'b0;
      sign_q        <= 1'b0;
      zero_q        <= 1'b0;
      ea_q          <= 8'd0;
      eb_q          <= 8'd0;
      ma_q          <= 24'd0;
      mb_q          <= 24'd0;
      mx_q          <= 24'd0;
      my_q          <= 24'd0;
      exp_q         <= 10'sd0;
      mant_q        <= 48'd0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      in_ack_q      <= in_ack_d;
      out_rdy_q     <= out_rdy_d;
      result_q      <= result_d;
      is_mul_q      <= is_mul_d;
      special_q     <= special_d;
      special_res_q <= special_res_d;
      sa_q          <= sa_d;
      sb_q          <= sb_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      sign_q        <= sign_d;
      zero_q        <= zero_d;
      ea_q          <= ea_d;
      eb_q          <= eb_d;
      ma_q          <= ma_d;
      mb_q          <= mb_d;
      mx_q          <= mx_d;
      my_q          <= my_d;
      exp_q         <= exp_d;
      mant_q        <= mant_d;
    end
  end

  assign input_ack  = in_ack_q;
  assign output_rdy = out_rdy_q;
  assign result     = result_q;

endmodule

// File: tb/tb_fpu.sv
// Directed-vector bench for fpu: results, latency, handshake holding and reset abort.
module tb_fpu;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  operation;
  logic [31:0] data_a, data_b;
  logic        input_rdy, output_ack;
  logic        input_ack, output_rdy;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  fpu dut (
    .clock      (clk),
    .reset      (reset),
    .operation  (operation),
    .data_a     (data_a),
    .data_b     (data_b),
    .input_rdy  (input_rdy),
    .input_ack  (input_ack),
    .output_rdy (output_rdy),
    .output_ack (output_ack),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns idle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int hold);
    int cyc;
    operation = op;
    data_a    = a;
    data_b    = b;
    input_rdy = 1'b1;
    @(posedge clk); #1;
    input_rdy = 1'b0;
    check({tag, "/ack"}, {31'd0, input_ack}, 32'd1);
    cyc = 0;
    while (!output_rdy && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "/latency"}, 32'(cyc), 32'd6);
    check({tag, "/ack_hold"}, {31'd0, input_ack}, 32'd1);
    check({tag, "/result"}, result, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_rdy"}, {31'd0, output_rdy}, 32'd1);
      check({tag, "/hold_result"}, result, exp_res);
    end
    output_ack = 1'b1;
    @(posedge clk); #1;
    output_ack = 1'b0;
    check({tag, "/flags_drop"}, {30'd0, input_ack, output_rdy}, 32'd0);
    $display("TXN %s op=%h a=%h b=%h result=%h expected=%h", tag, op, a, b, result, exp_res);
  endtask

  initial begin
    reset      = 1'b1;
    operation  = 4'd0;
    data_a     = 32'd0;
    data_b     = 32'd0;
    input_rdy  = 1'b0;
    output_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_flags", {30'd0, input_ack, output_rdy}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("add_1p0",      4'b0000, 32'h3F800000, 32'h3C23D70A, 32'h3F8147AE, 10);
    run_op("add_21",       4'b0000, 32'h41A80000, 32'h3E947AE1, 32'h41AA51EB, 0);
    run_op("add_neg_pos",  4'b0000, 32'hBF800000, 32'h41433333, 32'h41333333, 0);
    run_op("add_neg_neg",  4'b0000, 32'hBF800000, 32'hC1433333, 32'hC1533333, 0);
    run_op("add_shiftout", 4'b0000, 32'h7E967699, 32'hBF8CCCCD, 32'h7E967699, 0);
    run_op("add_carry",    4'b0000, 32'h3F800000, 32'h3F800000, 32'h40000000, 0);
    run_op("sub_norm",     4'b0001, 32'h3FC00000, 32'h3FA00000, 32'h3E800000, 0);
    run_op("sub_exact0",   4'b0001, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 0);
    run_op("add_zero",     4'b0000, 32'h40490FDB, 32'h00000000, 32'h40490FDB, 0);
    run_op("add_ovf",      4'b0000, 32'h7F000000, 32'h7F000000, 32'h7F800000, 0);
    run_op("inf_plus",     4'b0000, 32'h7F800000, 32'hBF8CCCCD, 32'h7F800000, 0);
    run_op("nan_in",       4'b0000, 32'hFF8CCCCD, 32'h7F8CCCCD, 32'hFFFFFFFF, 0);
    run_op("inf_sub_inf",  4'b0001, 32'h7F800000, 32'h7F800000, 32'hFFFFFFFF, 0);
    run_op("bad_op",       4'b0111, 32'h3F800000, 32'h3F800000, 32'hFFFFFFFF, 0);
    run_op("inf_mul_0",    4'b0010, 32'h7F800000, 32'h00000000, 32'hFFFFFFFF, 0);
`ifdef FPU_MUL_EN
    run_op("mul_2x2",      4'b0010, 32'h40000000, 32'h40000000, 32'h40800000, 0);
    run_op("mul_neg0",     4'b0010, 32'h40400000, 32'h80000000, 32'h80000000, 0);
    run_op("mul_1p5sq",    4'b0010, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 0);
`else
    run_op("mul_off",      4'b0010, 32'h40000000, 32'h40000000, 32'hFFFFFFFF, 0);
`endif

    // Abort an operation with reset while it is in COMPUTE.
    operation = 4'b0000;
    data_a    = 32'h3F800000;
    data_b    = 32'h3F800000;
    input_rdy = 1'b1;
    @(posedge clk); #1;
    input_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_result", result, 32'd0);
    check("abort_flags", {30'd0, input_ack, output_rdy}, 32'd0);
    $display("TXN abort result=%h input_ack=%b output_rdy=%b", result, input_ack, output_rdy);
    repeat (8) @(posedge clk);
    #1;
    check("abort_idle", {30'd0, input_ack, output_rdy}, 32'd0);
    run_op("post_reset",   4'b0000, 32'h41A80000, 32'h3E947AE1, 32'h41AA51EB, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
